mult_request_scheduler: RTL and testbench

//  Shares one sequential multiplier core (shift-and-accumulate, multi-cycle) between NREQ requesters.

---
 rtl/mult_request_scheduler.sv | 156 +++++++++++++++
 tb/tb_mult_request_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_request_scheduler.sv
// Round-robin front end that shares one multi-cycle multiplier core between NREQ
// requesters, with a completion watchdog and a single valid/ready response port.
module mult_request_scheduler #(
    parameter int  NREQ    = 4,
    parameter int  WIDTH   = 32,
    parameter int  TIMEOUT = 64,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_m,
    input  logic [NREQ*WIDTH-1:0] req_q,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  rsp_err,
    output logic                  core_start,
    output logic                  core_abort,
    output logic [WIDTH-1:0]      core_m,
    output logic [WIDTH-1:0]      core_q,
    input  logic                  core_done,
    input  logic [2*WIDTH-1:0]    core_product
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 err_q, err_d;

    logic                 win_found;
    logic [IDW-1:0]       win_idx;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        return IDW'((int'(base) + off) % NREQ);
    endfunction

    // Search starts at rr_ptr so the most recently served requester has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            if (!win_found && req_valid[wrap_add(rr_ptr_q, off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_q, off);
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        q_d        = q_q;
        id_d       = id_q;
        prod_d     = prod_q;
        err_d      = err_q;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        core_start = 1'b0;
        core_abort = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    m_d      = WIDTH'(req_m >> (int'(win_idx) * WIDTH));
                    q_d      = WIDTH'(req_q >> (int'(win_idx) * WIDTH));
                    id_d     = win_idx;
                    rr_ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the last allowed cycle still counts as success.
                if (core_done) begin
                    prod_d  = core_product;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    prod_d     = '0;
                    err_d      = 1'b1;
                    core_abort = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset wins immediately: no handshake, response or core pulse during it.
        if (reset) begin
            req_ready  = '0;
            rsp_valid  = 1'b0;
            core_start = 1'b0;
            core_abort = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            id_q     <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            q_q      <= q_d;
            id_q     <= id_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign rsp_err     = err_q;
    assign core_m      = m_q;
    assign core_q      = q_q;

endmodule

// File: tb/tb_mult_request_scheduler.sv
// Self-checking bench: transaction-level model of arbitration, core timing and watchdog,
// compared against the scheduler every cycle, plus directed literal scenarios.
module tb_mult_request_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_m, req_q;
    logic                  rsp_valid, rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_product;
    logic                  rsp_err;
    logic                  core_start, core_abort;
    logic [WIDTH-1:0]      core_m, core_q;
    logic                  core_done;
    logic [2*WIDTH-1:0]    core_product;

    always #5 clk = ~clk;

    mult_request_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_q(req_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .core_start(core_start), .core_abort(core_abort), .core_m(core_m), .core_q(core_q),
        .core_done(core_done), .core_product(core_product)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester and environment knobs
    bit          pend[NREQ];
    logic [31:0] pm[NREQ], pq[NREQ];
    bit          rand_mode = 0, refill = 0, rst_drv = 1, stray_now = 0, use_force_k = 0;
    int          rsp_policy = 1;   // 0 random, 1 always ready, 2 never ready
    int          force_k = 0;

    // Transaction model: age counts cycles since the accepting cycle
    bit          busy = 0, exp_err = 0;
    int          age = 0, rsp_age = 0, done_age = -1, rr = 0, exp_id = 0;
    logic [31:0] exp_m = '0, exp_q = '0;
    logic [63:0] exp_prod = '0;

    // Observations of the DUT, compared only against hand-computed literals
    int          obs_grants[$];
    int          obs_starts = 0, obs_aborts = 0, obs_rsps = 0, ready_cycles = 0;
    int          grant_cyc = 0, lat = 0, last_id = 0;
    bit          last_err = 0, rsp_valid_prev = 0;
    logic [63:0] last_prod = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic grant(input int w);
        int k;
        busy   = 1;
        age    = 1;
        exp_id = w;
        exp_m  = pm[w];
        exp_q  = pq[w];
        pend[w] = 0;
        rr     = (w + 1) % NREQ;
        if (use_force_k) begin
            k = force_k;
            use_force_k = 0;
        end else if (rand_mode) begin
            case ($urandom_range(0, 19))
                0:       k = -1;
                1:       k = TIMEOUT;
                2:       k = TIMEOUT - 1;
                default: k = $urandom_range(1, 12);
            endcase
        end else begin
            k = 3;
        end
        // The core reports k cycles after the launch cycle; WAIT spans ages 2..TIMEOUT+1.
        done_age = (k < 0) ? -1 : 1 + k;
        if (done_age >= 2 && done_age <= TIMEOUT + 1) begin
            rsp_age  = done_age + 1;
            exp_err  = 0;
            exp_prod = {32'b0, exp_m} * {32'b0, exp_q};
        end else begin
            rsp_age  = TIMEOUT + 2;
            exp_err  = 1;
            exp_prod = '0;
        end
    endtask

    task automatic step();
        bit in_wait, in_resp, model_done, stray;
        int w;
        logic [NREQ-1:0] e_ready;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (refill && !pend[i]) begin
                pend[i] = 1; pm[i] = rnd_op(); pq[i] = rnd_op();
            end else if (rand_mode) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; pm[i] = rnd_op(); pq[i] = rnd_op();
                end else if (pend[i] && $urandom_range(0, 15) == 0) begin
                    pend[i] = 0;
                end
            end
            req_valid[i] = pend[i];
            req_m[i*WIDTH +: WIDTH] = pm[i];
            req_q[i*WIDTH +: WIDTH] = pq[i];
        end
        rsp_ready = (rsp_policy == 1) ? 1'b1 :
                    (rsp_policy == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        reset = rst_drv;
        in_wait    = busy && age >= 2 && age < rsp_age;
        model_done = busy && !rst_drv && age == done_age;
        stray      = !in_wait && (stray_now || (rand_mode && $urandom_range(0, 7) == 0));
        core_done    = model_done || stray;
        core_product = model_done ? {32'b0, exp_m} * {32'b0, exp_q} : {$urandom(), $urandom()};
        #1;

        w = -1;
        if (!busy)
            for (int off = 0; off < NREQ; off++)
                if (w < 0 && pend[(rr + off) % NREQ]) w = (rr + off) % NREQ;
        e_ready = (rst_drv || busy || w < 0) ? '0 : NREQ'(1) << w;
        in_resp = busy && age >= rsp_age;

        check("req_ready", req_ready, e_ready);
        check("rsp_valid", rsp_valid, !rst_drv && in_resp);
        check("core_start", core_start, !rst_drv && busy && age == 1);
        check("core_abort", core_abort, !rst_drv && busy && exp_err && age == rsp_age - 1);
        if (!rst_drv && in_resp) begin
            check("rsp_id", rsp_id, exp_id);
            check("rsp_product", rsp_product, exp_prod);
            check("rsp_err", rsp_err, exp_err);
        end
        if (!rst_drv && busy && age >= 1 && age < rsp_age) begin
            check("core_m", core_m, exp_m);
            check("core_q", core_q, exp_q);
        end

        for (int i = 0; i < NREQ; i++)
            if (req_ready[i] && req_valid[i]) begin
                obs_grants.push_back(i);
                grant_cyc = cyc;
            end
        if (req_ready != '0) ready_cycles++;
        if (core_start) obs_starts++;
        if (core_abort) obs_aborts++;
        if (rsp_valid && !rsp_valid_prev) lat = cyc - grant_cyc;
        rsp_valid_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            obs_rsps++;
            last_id   = int'(rsp_id);
            last_prod = rsp_product;
            last_err  = rsp_err;
        end

        if (rst_drv) begin
            busy = 0;
            rr   = 0;
        end else if (busy) begin
            if (in_resp && rsp_ready) busy = 0;
            else age++;
        end else if (w >= 0) begin
            grant(w);
        end
        stray_now = 0;
        cyc++;
    endtask

    task automatic run_op(input string name, input int max);
        int n = 0;
        while (!busy && n < max) begin step(); n++; end
        while (busy && n < max) begin step(); n++; end
        check({name, "_bound"}, n < max, 1);
    endtask

    task automatic do_reset();
        rst_drv = 1;
        step();
        rst_drv = 0;
    endtask

    initial begin
        int n, g0, rc0, s0, a0, r0;
        int t2_order[6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pm[i] = '0; pq[i] = '0; end
        req_valid = '0; req_m = '0; req_q = '0; rsp_ready = 1'b0;
        core_done = 1'b0; core_product = '0; reset = 1'b1;

        repeat (3) step();
        rst_drv = 0;
        step();
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_product", rsp_product, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_core_m", core_m, 0);
        check("reset_core_q", core_q, 0);

        // T1: 3*5 with a 33-cycle core
        pend[0] = 1; pm[0] = 3; pq[0] = 5; use_force_k = 1; force_k = 33;
        run_op("t1", 200);
        check("t1_latency", lat, 35);
        check("t1_product", last_prod, 64'd15);
        check("t1_id", last_id, 0);
        check("t1_err", last_err, 0);

        // T3: largest operands
        pend[2] = 1; pm[2] = 32'hFFFF_FFFF; pq[2] = 32'hFFFF_FFFF; use_force_k = 1; force_k = 10;
        run_op("t3", 200);
        check("t3_product", last_prod, 64'hFFFF_FFFE_0000_0001);
        check("t3_id", last_id, 2);

        // T2: everyone requesting continuously after reset
        do_reset();
        refill = 1; g0 = obs_grants.size(); rc0 = ready_cycles; n = 0;
        while (obs_grants.size() < g0 + 6 && n < 500) begin step(); n++; end
        check("t2_bound", n < 500, 1);
        for (int i = 0; i < 6; i++)
            if (g0 + i < obs_grants.size()) check("t2_order", obs_grants[g0+i], t2_order[i]);
        check("t2_ready_cycles", ready_cycles - rc0, 6);
        refill = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        n = 0;
        while (busy && n < 200) begin step(); n++; end

        // T4: back-pressure in RESP while another requester waits
        rsp_policy = 2; pend[3] = 1; pm[3] = 6; pq[3] = 7; use_force_k = 1; force_k = 2;
        n = 0;
        while (!(busy && age >= rsp_age) && n < 200) begin step(); n++; end
        s0 = obs_starts; rc0 = ready_cycles;
        pend[0] = 1; pm[0] = 9; pq[0] = 9;
        repeat (10) step();
        check("t4_no_start", obs_starts - s0, 0);
        check("t4_no_ready", ready_cycles - rc0, 0);
        check("t4_rsp_held", rsp_valid, 1);
        rsp_policy = 1;
        n = 0;
        while (busy && n < 50) begin step(); n++; end
        check("t4_product", last_prod, 64'd42);
        run_op("t4b", 200);
        check("t4b_product", last_prod, 64'd81);
        check("t4b_id", last_id, 0);

        // T5: watchdog abort, then normal service, then done on the final WAIT cycle
        a0 = obs_aborts;
        pend[0] = 1; pm[0] = 11; pq[0] = 13; use_force_k = 1; force_k = -1;
        run_op("t5", 300);
        check("t5_aborts", obs_aborts - a0, 1);
        check("t5_err", last_err, 1);
        check("t5_product", last_prod, 0);
        check("t5_id", last_id, 0);
        pend[1] = 1; pm[1] = 7; pq[1] = 6; use_force_k = 1; force_k = 5;
        run_op("t5b", 200);
        check("t5b_product", last_prod, 64'd42);
        check("t5b_err", last_err, 0);
        check("t5b_id", last_id, 1);
        a0 = obs_aborts;
        pend[2] = 1; pm[2] = 2; pq[2] = 50; use_force_k = 1; force_k = TIMEOUT;
        run_op("t5c", 300);
        check("t5c_product", last_prod, 64'd100);
        check("t5c_err", last_err, 0);
        check("t5c_no_abort", obs_aborts - a0, 0);

        // T6: reset while waiting, late core_done must not produce a response
        pend[2] = 1; pm[2] = 5; pq[2] = 5; use_force_k = 1; force_k = 20;
        n = 0;
        while (!(busy && age == 6) && n < 200) begin step(); n++; end
        r0 = obs_rsps; a0 = obs_aborts;
        do_reset();
        stray_now = 1;
        step();
        repeat (3) step();
        check("t6_no_rsp", obs_rsps - r0, 0);
        check("t6_no_abort", obs_aborts - a0, 0);
        g0 = obs_grants.size();
        pend[0] = 0; pend[1] = 1; pm[1] = 4; pq[1] = 4;
        run_op("t6", 200);
        if (g0 < obs_grants.size()) check("t6_first_grant", obs_grants[g0], 1);
        else check("t6_grant_seen", obs_grants.size(), g0 + 1);
        check("t6_product", last_prod, 64'd16);

        // Randomized traffic against the model
        rand_mode = 1; rsp_policy = 0;
        repeat (3000) step();
        rand_mode = 0; rsp_policy = 1;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        check("drain_bound", n < 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
